// File: rtl/vga_pkg.sv
// Shared timing constants and colour type for the 640x480@60 Hz raster scan.
package vga_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int CNT_W   = 10;
   localparam int FRAME_W = 8;

   typedef logic [11:0] color_t;

   localparam color_t COLOR_WHITE = 12'hFFF;
   localparam color_t COLOR_BLACK = 12'h000;

endpackage

// File: rtl/vga_sync_cnt.sv
// Horizontal/vertical scan counters with visible and sync decode.
// Produces the stage-0 registered address, rdn and (undelayed) sync levels.
module vga_sync_cnt
   import vga_pkg::*;
#(
   parameter int P_H_VIS  = H_VIS,
   parameter int P_H_FP   = H_FP,
   parameter int P_H_SYNC = H_SYNC,
   parameter int P_H_BP   = H_BP,
   parameter int P_V_VIS  = V_VIS,
   parameter int P_V_FP   = V_FP,
   parameter int P_V_SYNC = V_SYNC,
   parameter int P_V_BP   = V_BP
)(
   input  logic       i_clk,
   input  logic       i_rst,
   output logic [8:0] o_row_addr,
   output logic [9:0] o_col_addr,
   output logic       o_rdn,
   output logic       o_hs_n,
   output logic       o_vs_n,
   output logic       o_vblank_start
);

   localparam logic [CNT_W-1:0] L_H_VIS  = CNT_W'(P_H_VIS);
   localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP - 1);
   localparam logic [CNT_W-1:0] L_HS_BEG = CNT_W'(P_H_VIS + P_H_FP);
   localparam logic [CNT_W-1:0] L_HS_END = CNT_W'(P_H_VIS + P_H_FP + P_H_SYNC);
   localparam logic [CNT_W-1:0] L_V_VIS  = CNT_W'(P_V_VIS);
   localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP - 1);
   localparam logic [CNT_W-1:0] L_VS_BEG = CNT_W'(P_V_VIS + P_V_FP);
   localparam logic [CNT_W-1:0] L_VS_END = CNT_W'(P_V_VIS + P_V_FP + P_V_SYNC);

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic             w_visible;
   logic             w_hs_n;
   logic             w_vs_n;

   assign w_visible      = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
   assign w_hs_n         = !((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END));
   assign w_vs_n         = !((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END));
   assign o_vblank_start = (r_h_cnt == '0) && (r_v_cnt == L_V_VIS);

   // Free-running raster position; v advances on h wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == L_H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
         r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
   end

   // Stage 0: registered addresses (zeroed in blanking) and sync levels.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_row_addr <= '0;
         o_col_addr <= '0;
         o_rdn      <= 1'b1;
         o_hs_n     <= 1'b1;
         o_vs_n     <= 1'b1;
      end else begin
         o_row_addr <= w_visible ? r_v_cnt[8:0] : 9'd0;
         o_col_addr <= w_visible ? r_h_cnt      : 10'd0;
         o_rdn      <= !w_visible;
         o_hs_n     <= w_hs_n;
         o_vs_n     <= w_vs_n;
      end
   end

endmodule

// File: rtl/vga_scan.sv
// Raster scan top: address issue, one-cycle colour return pipeline,
// sync delayed to match colour, and the per-N-frame game tick.
// Optional VGA_BORDER_EN: force a white one-pixel frame around the screen.
module vga_scan
   import vga_pkg::*;
#(
   parameter int P_H_VIS     = H_VIS,
   parameter int P_H_FP      = H_FP,
   parameter int P_H_SYNC    = H_SYNC,
   parameter int P_H_BP      = H_BP,
   parameter int P_V_VIS     = V_VIS,
   parameter int P_V_FP      = V_FP,
   parameter int P_V_SYNC    = V_SYNC,
   parameter int P_V_BP      = V_BP,
   parameter int P_FRESH_DIV = 1
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [11:0] i_px_rgb,
   output logic [8:0]  o_row_addr,
   output logic [9:0]  o_col_addr,
   output logic        o_rdn,
   output logic        o_fresh,
   output logic        o_hs,
   output logic        o_vs,
   output logic [3:0]  o_r,
   output logic [3:0]  o_g,
   output logic [3:0]  o_b
);

   localparam logic [FRAME_W-1:0] L_DIV_LAST = FRAME_W'(P_FRESH_DIV - 1);

   logic              w_rdn;
   logic              w_hs_n;
   logic              w_vs_n;
   logic              w_vblank_start;
   color_t            w_pix;
   color_t            r_rgb;
   logic              r_hs_n;
   logic              r_vs_n;
   logic [FRAME_W-1:0] r_frame;
   logic              r_fresh;

   vga_sync_cnt #(
      .P_H_VIS  (P_H_VIS),
      .P_H_FP   (P_H_FP),
      .P_H_SYNC (P_H_SYNC),
      .P_H_BP   (P_H_BP),
      .P_V_VIS  (P_V_VIS),
      .P_V_FP   (P_V_FP),
      .P_V_SYNC (P_V_SYNC),
      .P_V_BP   (P_V_BP)
   ) u_sync_cnt (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .o_row_addr     (o_row_addr),
      .o_col_addr     (o_col_addr),
      .o_rdn          (w_rdn),
      .o_hs_n         (w_hs_n),
      .o_vs_n         (w_vs_n),
      .o_vblank_start (w_vblank_start)
   );

   assign o_rdn = w_rdn;

`ifdef VGA_BORDER_EN
   localparam logic [8:0] L_ROW_LAST = 9'(P_V_VIS - 1);
   localparam logic [9:0] L_COL_LAST = 10'(P_H_VIS - 1);

   logic w_border;

   // Stage-0 addresses are the ones the renderer answered, so the border
   // decision lines up with the returned colour.
   assign w_border = (o_row_addr == 9'd0) || (o_row_addr == L_ROW_LAST) ||
                     (o_col_addr == 10'd0) || (o_col_addr == L_COL_LAST);
   assign w_pix    = w_border ? COLOR_WHITE : i_px_rgb;
`else
   assign w_pix    = i_px_rgb;
`endif

   // Stage 1: capture renderer colour, blank it outside the visible area,
   // and delay sync by the same amount.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rgb  <= COLOR_BLACK;
         r_hs_n <= 1'b1;
         r_vs_n <= 1'b1;
      end else begin
         r_rgb  <= w_rdn ? COLOR_BLACK : w_pix;
         r_hs_n <= w_hs_n;
         r_vs_n <= w_vs_n;
      end
   end

   // Frame divider: tick once every P_FRESH_DIV vblank starts.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frame <= '0;
         r_fresh <= 1'b0;
      end else begin
         r_fresh <= 1'b0;
         if (w_vblank_start) begin
            if (r_frame == L_DIV_LAST) begin
               r_frame <= '0;
               r_fresh <= 1'b1;
            end else begin
               r_frame <= r_frame + FRAME_W'(1);
            end
         end
      end
   end

   assign o_fresh = r_fresh;
   assign o_hs    = r_hs_n;
   assign o_vs    = r_vs_n;
   assign o_r     = r_rgb[11:8];
   assign o_g     = r_rgb[7:4];
   assign o_b     = r_rgb[3:0];

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan on a shrunken raster (32x19 total, 20x12
// visible) so several frames fit in a short run. Honours VGA_BORDER_EN.
module tb_vga_scan;
   import vga_pkg::*;

   localparam int HV = 20, HF = 3, HS = 5, HB = 4, HT = 32;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = 19;
   localparam int FRAME = HT * VT;   // 608
   localparam int DIV   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [11:0] px_rgb;
   logic [8:0] row_addr;
   logic [9:0] col_addr;
   logic       rdn, fresh, hs, vs;
   logic [3:0] r, g, b;
   logic       px_zero = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rdn_low_cnt, hs_low_cnt, vs_low_cnt, fresh_cnt, hs_fall, p1, p2;
   logic prev_hs;

   vga_scan #(
      .P_H_VIS (HV), .P_H_FP (HF), .P_H_SYNC (HS), .P_H_BP (HB),
      .P_V_VIS (VV), .P_V_FP (VF), .P_V_SYNC (VS), .P_V_BP (VB),
      .P_FRESH_DIV (DIV)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_px_rgb   (px_rgb),
      .o_row_addr (row_addr),
      .o_col_addr (col_addr),
      .o_rdn      (rdn),
      .o_fresh    (fresh),
      .o_hs       (hs),
      .o_vs       (vs),
      .o_r        (r),
      .o_g        (g),
      .o_b        (b)
   );

   always #5 clk = ~clk;

   // Renderer model: colour derived from the issued address.
   always @* px_rgb = px_zero ? 12'h000 : {row_addr[3:0], col_addr[3:0], 4'h5};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic bit vis(int idx);
      int h, v;
      if (idx < 0) return 1'b0;
      h = idx % HT;
      v = (idx / HT) % VT;
      return (h < HV) && (v < VV);
   endfunction

   function automatic int exp_rgb(int idx);
      int h, v;
      if (!vis(idx)) return 0;
      h = idx % HT;
      v = (idx / HT) % VT;
`ifdef VGA_BORDER_EN
      if (v == 0 || v == VV - 1 || h == 0 || h == HV - 1) return 'hFFF;
`endif
      if (px_zero) return 0;
      return (v % 16) * 256 + (h % 16) * 16 + 5;
   endfunction

   function automatic int exp_hs(int idx);
      int h;
      if (idx < 0) return 1;
      h = idx % HT;
      return (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
   endfunction

   function automatic int exp_vs(int idx);
      int v;
      if (idx < 0) return 1;
      v = (idx / HT) % VT;
      return (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
   endfunction

   function automatic int exp_fresh(int idx);
      if (idx < 0) return 0;
      return ((idx % FRAME) == VV * HT && ((idx / FRAME) % DIV) == DIV - 1) ? 1 : 0;
   endfunction

   task automatic clear_stats();
      rdn_low_cnt = 0; hs_low_cnt = 0; vs_low_cnt = 0;
      fresh_cnt = 0; hs_fall = 0; p1 = 0; p2 = 0; prev_hs = 1'b1;
   endtask

   // One clock: sample after the edge and compare every output to the model.
   task automatic step();
      int i0, i1;
      @(posedge clk);
      #1;
      cyc++;
      i0 = cyc - 1;
      i1 = cyc - 2;
      chk("row_addr", 32'(row_addr), vis(i0) ? 32'((i0 / HT) % VT) : 32'd0);
      chk("col_addr", 32'(col_addr), vis(i0) ? 32'(i0 % HT) : 32'd0);
      chk("rdn",      32'(rdn),      vis(i0) ? 32'd0 : 32'd1);
      chk("rgb",      32'({r, g, b}), 32'(exp_rgb(i1)));
      chk("hs",       32'(hs),       32'(exp_hs(i1)));
      chk("vs",       32'(vs),       32'(exp_vs(i1)));
      chk("fresh",    32'(fresh),    32'(exp_fresh(i0)));
      if (!rdn) rdn_low_cnt++;
      if (!hs)  hs_low_cnt++;
      if (!vs)  vs_low_cnt++;
      if (!hs && prev_hs && hs_fall == 0) hs_fall = cyc;
      prev_hs = hs;
      if (fresh) begin
         fresh_cnt++;
         if (fresh_cnt == 1) p1 = cyc;
         if (fresh_cnt == 2) p2 = cyc;
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_row"},   32'(row_addr), 32'd0);
      chk({pfx, "_col"},   32'(col_addr), 32'd0);
      chk({pfx, "_rdn"},   32'(rdn),      32'd1);
      chk({pfx, "_fresh"}, 32'(fresh),    32'd0);
      chk({pfx, "_hs"},    32'(hs),       32'd1);
      chk({pfx, "_vs"},    32'(vs),       32'd1);
      chk({pfx, "_rgb"},   32'({r, g, b}), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      clear_stats();
      repeat (5) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;

      // first visible cycle
      step();
      chk("first_row", 32'(row_addr), 32'd0);
      chk("first_col", 32'(col_addr), 32'd0);
      chk("first_rdn", 32'(rdn),      32'd0);

      // one line
      run_to(HT);
      chk("line_rdn_low", 32'(rdn_low_cnt), 32'd20);
      chk("line_hs_low",  32'(hs_low_cnt),  32'd5);
      chk("hs_fall_cyc",  32'(hs_fall),     32'd25);

      // one frame
      run_to(FRAME);
      chk("frame_rdn_low", 32'(rdn_low_cnt), 32'd240);
      chk("frame_vs_low",  32'(vs_low_cnt),  32'd64);
      chk("frame_fresh",   32'(fresh_cnt),   32'd0);

      // seven frames with divide-by-3 tick
      run_to(7 * FRAME);
      chk("fresh_pulses", 32'(fresh_cnt), 32'd2);
      chk("fresh_p1",     32'(p1),        32'd1601);
      chk("fresh_p2",     32'(p2),        32'd3425);
      chk("fresh_gap",    32'(p2 - p1),   32'd1824);

      // mid-frame reset at row 5, divider holding 2
      run_to(8 * FRAME + 5 * HT + 7);
      chk("pre_rst_rdn", 32'(rdn), 32'd0);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      repeat (3) @(posedge clk);
`ifdef VGA_BORDER_EN
      px_zero = 1'b1;
`endif
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      clear_stats();

      step();
      chk("restart_row", 32'(row_addr), 32'd0);
      chk("restart_col", 32'(col_addr), 32'd0);
      chk("restart_rdn", 32'(rdn),      32'd0);

      run_to(7);
`ifdef VGA_BORDER_EN
      chk("rgb_r0_c5", 32'({r, g, b}), 32'hFFF);
`else
      chk("rgb_r0_c5", 32'({r, g, b}), 32'h055);
`endif
      run_to(35);
`ifdef VGA_BORDER_EN
      chk("rgb_r1_c1", 32'({r, g, b}), 32'h000);
`else
      chk("rgb_r1_c1", 32'({r, g, b}), 32'h115);
`endif
      run_to(117);
`ifdef VGA_BORDER_EN
      chk("rgb_r3_clast", 32'({r, g, b}), 32'hFFF);
`else
      chk("rgb_r3_clast", 32'({r, g, b}), 32'h335);
`endif

      run_to(1600);
      chk("no_early_fresh", 32'(fresh_cnt), 32'd0);
      run_to(1602);
      chk("restart_fresh_cnt", 32'(fresh_cnt), 32'd1);
      chk("restart_fresh_p1",  32'(p1),        32'd1601);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
